// File: rtl/contador_comparador_n.sv
// N-bit modulus counter (up/down, load, optional saturation) with a magnitude
// comparator against a reference word, an equality-entry pulse and a sticky overflow flag.
module contador_comparador_n #(
  parameter int N      = 4,
  parameter int MODULO = 16,
  parameter int SATURA = 0
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         carrega,
  input  logic         conta,
  input  logic         desce,
  input  logic [N-1:0] chaves,
  input  logic [N-1:0] referencia,
  output logic [N-1:0] contagem,
  output logic         menor,
  output logic         maior,
  output logic         igual,
  output logic         fim,
  output logic         igual_pulso,
  output logic         estouro,
  output logic [N-1:0] db_contagem
);

  // One extra bit so that MODULO = 2**N still yields a representable top value.
  localparam logic [N:0]   MAX_EXT = (N+1)'(MODULO - 1);
  localparam logic [N-1:0] MAX_VAL = MAX_EXT[N-1:0];
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam bit           SAT     = (SATURA != 0);

  logic [N-1:0] contagem_q, contagem_d;
  logic         estouro_q, estouro_d;
  logic         igual_ant_q, igual_ant_d;
  logic         igual_pulso_q, igual_pulso_d;

  logic         no_topo;
  logic         no_zero;
  logic [N-1:0] carga;

  always_comb begin
    no_topo = ({1'b0, contagem_q} == MAX_EXT);
    no_zero = (contagem_q == '0);
    carga   = ({1'b0, chaves} > MAX_EXT) ? MAX_VAL : chaves;
  end

  always_comb begin
    menor = (contagem_q <  referencia);
    maior = (contagem_q >  referencia);
    igual = (contagem_q == referencia);
    fim   = desce ? no_zero : no_topo;
  end

  always_comb begin
    contagem_d    = contagem_q;
    estouro_d     = estouro_q;
    igual_ant_d   = igual;
    igual_pulso_d = igual & ~igual_ant_q;
    if (zera) begin
      contagem_d    = '0;
      estouro_d     = 1'b0;
      igual_ant_d   = 1'b0;
      igual_pulso_d = 1'b0;
    end else if (carrega) begin
      contagem_d = carga;
    end else if (conta) begin
      if (!desce) begin
        if (!no_topo) begin
          contagem_d = contagem_q + ONE;
        end else begin
          estouro_d  = 1'b1;
          contagem_d = SAT ? contagem_q : '0;
        end
      end else begin
        if (!no_zero) begin
          contagem_d = contagem_q - ONE;
        end else begin
          estouro_d  = 1'b1;
          contagem_d = SAT ? contagem_q : MAX_VAL;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    contagem_q    <= contagem_d;
    estouro_q     <= estouro_d;
    igual_ant_q   <= igual_ant_d;
    igual_pulso_q <= igual_pulso_d;
  end

  assign contagem    = contagem_q;
  assign db_contagem = contagem_q;
  assign estouro     = estouro_q;
  assign igual_pulso = igual_pulso_q;

endmodule

// File: doc/contador_comparador_n.md
Name: contador_comparador_n

Overview:
- Parametrised successor to the 4-bit counter/comparator datapath: N-bit synchronous counter with programmable modulus, up/down counting, parallel load, and optional saturation.
- Built-in magnitude comparator checks the count against an independent reference word.
- Adds a registered match pulse and a sticky wrap/overflow flag.
- Used as the counting/compare datapath under the experiment control units, in place of the fixed 4-bit counter plus comparator pair.

Parameters:
- N, 4, counter and compare width in bits (N >= 2).
- MODULO, 16, count range 0..MODULO-1. Requires 2 <= MODULO <= 2**N.
- SATURA, 0, 0 = wrap at range limits; 1 = hold at range limits.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- zera  input  1  synchronous reset, active-high; clears all state
- carrega  input  1  synchronous parallel load, active-high
- conta  input  1  count enable, active-high
- desce  input  1  direction: 0 = count up, 1 = count down
- chaves  input  N  parallel load value
- referencia  input  N  comparison operand B
- contagem  output  N  current count (register)
- menor  output  1  contagem < referencia (combinational)
- maior  output  1  contagem > referencia (combinational)
- igual  output  1  contagem == referencia (combinational)
- fim  output  1  terminal count (combinational)
- igual_pulso  output  1  one-cycle registered pulse on entry into equality
- estouro  output  1  sticky wrap/limit-hit flag (register)
- db_contagem  output  N  debug copy of contagem

Behaviour:
- Interface (already decided): single clock `clock`; reset `zera` is synchronous and active-high.
- Priority at each rising edge: zera > carrega > conta. When none is asserted, all registers hold.
- zera=1: contagem=0, estouro=0, igual_pulso=0, internal igual_d=0. Same-edge carrega/conta are ignored. Reset mid-count takes effect on that edge.
- carrega=1: contagem = chaves if chaves <= MODULO-1, else MODULO-1 (clamped). Load leaves estouro unchanged.
- conta=1, desce=0:
  - contagem < MODULO-1: contagem+1.
  - contagem == MODULO-1, SATURA=0: wraps to 0 and sets estouro.
  - contagem == MODULO-1, SATURA=1: holds and sets estouro.
- conta=1, desce=1:
  - contagem > 0: contagem-1.
  - contagem == 0, SATURA=0: wraps to MODULO-1 and sets estouro.
  - contagem == 0, SATURA=1: holds at 0 and sets estouro.
- estouro is sticky; it is cleared only by zera.
- fim = (~desce & contagem==MODULO-1) | (desce & contagem==0). Not qualified by conta.
- Comparator:
  - Unsigned N-bit compare of contagem against referencia.
  - Exactly one of menor/maior/igual is high at all times.
  - Combinational, so it changes in the same cycle referencia changes.
- igual_pulso:
  - Internal register igual_d <= igual each edge (0 on zera).
  - igual_pulso <= igual & ~igual_d, registered. It is high for exactly one cycle, one cycle after igual rises.
  - If igual stays high across cycles, there is no repeat pulse.
  - If zera is asserted while igual=1, the first cycle after reset release can produce a pulse (igual_d=0).
- Counter arithmetic is N bits wide. The comparison against MODULO-1 uses an N+1-bit constant so MODULO = 2**N is legal.
- No latency on flags except igual_pulso (1 cycle). contagem updates 1 cycle after the controlling input is sampled.
- Reset values:
  - contagem=0, estouro=0, igual_pulso=0.
  - fim=1 if desce=1 after reset.
  - menor/maior/igual follow referencia; igual=1 iff referencia=0.

Test Plan (N=4, MODULO=10 unless noted):
1. Up count with wrap (SATURA=0). zera, then conta=1, desce=0 for 12 cycles → contagem 0..9, then 0, 1. fim high only at 9. estouro rises on the edge 9→0 and stays 1.
2. Down count with wrap and saturation. Load 2, desce=1, conta=1 → 2, 1, 0, 9 with estouro set. Repeat with SATURA=1 → 2, 1, 0, 0, 0, with estouro set on the first hold.
3. Load clamp and priority:
   - chaves=13, carrega=1 → contagem=9.
   - Same cycle carrega=1, conta=1 → load wins.
   - zera=1 together with carrega=1, chaves=5 → contagem=0.
4. Comparator and pulse. referencia=6, up count from 0:
   - menor=1 for counts 0..5; igual=1 at 6; maior=1 at 7..9.
   - igual_pulso high for exactly the one cycle after contagem becomes 6.
   - Holding at 6 (conta=0) gives no second pulse.
5. Reference change. contagem=4 held. referencia steps 3 → 4 → 5 → maior, igual, menor in the same cycles. igual_pulso fires once, one cycle after referencia=4.
6. Full-range instance (N=4, MODULO=16). Up from 15 → 0 with estouro=1 and fim=1 at 15. Reset mid-count at 11 → contagem=0, estouro=0 on that edge.
